vscale_hasti_console: RTL and testbench
=======================================

Name: vscale_hasti_console

Overview:
- HASTI (AHB-Lite) slave peripheral on the core's dmem bus, beside the dual-port SRAM in the sim/FPGA top.
- Buffers bytes written by software into a TX FIFO and drains them over a valid/ready byte stream to a console sink.
- Holds a tohost mailbox register that the test harness polls for pass/fail.
- Uses single-slave HASTI semantics: address phase, then data phase, with wait states via hready.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.
- GAP, 0, minimum idle cycles between consecutive tx_valid handshakes (pacing).

Ports:
- hclk  in  1  clock.
- hresetn  in  1  synchronous active-low reset.
- haddr  in  32  address; only haddr[3:0] decoded.
- hwrite  in  1  1 = write.
- hsize  in  3  0 byte, 1 half, 2 word.
- hburst  in  3  ignored.
- hmastlock  in  1  ignored.
- hprot  in  4  ignored.
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- hwdata  in  32  write data (data phase).
- hrdata  out  32  read data (data phase).
- hready  out  1  data phase complete.
- hresp  out  1  0 OKAY, 1 ERROR.
- tx_valid  out  1  byte available to sink.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts when tx_valid & tx_ready.
- tohost  out  32  mailbox value.
- tohost_valid  out  1  mailbox non-zero.

Behaviour:
- Transfer accepted when htrans is NONSEQ or SEQ and hready = 1. IDLE and BUSY give an OKAY zero-wait response.
- Address phase registers offset, hwrite and hsize; the next cycle is the data phase.
- Register map:
  - 0x0 TXDATA: write pushes hwdata[7:0]; read returns 0.
  - 0x4 STATUS (RO): [0] empty, [1] full, [16:8] count.
  - 0x8 TOHOST: word access only, R/W.
  - 0xC CTRL: see Optional Feature.
- Errors: misaligned address (haddr[1:0] != 0), hsize > 2, non-word TOHOST access, and any write to STATUS.
  - Response is two cycles: cycle 1 hready = 0, hresp = 1; cycle 2 hready = 1, hresp = 1.
  - No state change on an errored access.
- Default latency: zero wait states. Read data is valid in the data phase while hready = 1.
- TXDATA write when FIFO full: hold hready = 0, hresp = 0 until a pop frees a slot. The push completes in the cycle the pop occurs; count stays unchanged that cycle.
- Push and pop in the same cycle with FIFO not full: both take effect; count unchanged.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - count = wr - rd, range 0..FIFO_DEPTH.
  - tx_data = mem[rd] whenever tx_valid is high.
  - tx_data and tx_valid are held stable until the handshake.
- Pacing:
  - tx_valid = !empty && gap_cnt == 0.
  - On handshake, gap_cnt loads GAP, then decrements once per cycle to 0.
  - GAP = 0 allows one pop per cycle.
- tohost_valid = (tohost != 0), combinational from the register.
- Reset (hresetn = 0 at a hclk edge):
  - Pointers, gap_cnt, tohost and CTRL clear.
  - Outputs: hready = 1, hresp = 0, hrdata = 0, tx_valid = 0, tx_data = 0, tohost = 0, tohost_valid = 0, irq = 0.
  - Reset asserted mid-stall abandons the pending transfer and its push.

Optional Feature:
- Macro: VSCALE_CONSOLE_IRQ_EN.
- Enabled:
  - Adds output port irq (1 bit).
  - CTRL register: [0] irq_en, [8:0]... no — [16:8] watermark.
  - irq is registered: irq = irq_en && count <= watermark, updated one cycle after count changes.
  - CTRL accepts word access only.
- Disabled:
  - No irq port.
  - CTRL reads 0.
  - Any CTRL access returns the ERROR response.

Test Plan:
- Reset, then read STATUS -> hrdata = 0x0000_0001, hready = 1, tx_valid = 0.
- Byte-write 0x41, 0x42, 0x43 to TXDATA with tx_ready = 1, GAP = 0 -> tx_data sequence 0x41, 0x42, 0x43 on consecutive cycles; STATUS returns to empty.
- tx_ready = 0; write FIFO_DEPTH+1 bytes -> the 17th data phase stalls (hready = 0). Raise tx_ready for one cycle -> 0x00 popped, 17th push completes, STATUS count = 16.
- Word-write 0x1 to TOHOST -> tohost = 1, tohost_valid = 1 in the next cycle.
  - Halfword write to TOHOST -> two-cycle ERROR, tohost unchanged.
  - Misaligned write to 0x1 -> ERROR.
- GAP = 3, 4 bytes queued, tx_ready = 1 -> handshakes 4 cycles apart.
  - Pull hresetn low mid-stream -> tx_valid = 0 and count = 0 on the next edge.
- With VSCALE_CONSOLE_IRQ_EN: CTRL = 0x0000_0201 (watermark 2, irq_en) with 5 bytes queued -> irq = 0, rises one cycle after count reaches 2.
  - Without the macro: CTRL write -> ERROR.

Source files
------------

// File: rtl/vscale_hasti_console.sv
// HASTI console slave: TX byte FIFO drained as a paced byte stream, plus tohost mailbox.
// Define VSCALE_CONSOLE_IRQ_EN to add the CTRL register and the irq output.
module vscale_hasti_console #(
  parameter int FIFO_DEPTH = 16,
  parameter int GAP        = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] tohost,
  output logic        tohost_valid
`ifdef VSCALE_CONSOLE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] OFF_TX = 2'd0;
  localparam logic [1:0] OFF_ST = 2'd1;
  localparam logic [1:0] OFF_TH = 2'd2;
  localparam logic [1:0] OFF_CT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    dp_off;
  logic          dp_write;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [8:0]    count9;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [GW-1:0] gap_cnt;
  logic          tohost_we;
  logic          addr_err;
  logic [31:0]   status;
  logic          unused;

`ifdef VSCALE_CONSOLE_IRQ_EN
  logic          irq_en;
  logic [8:0]    watermark;
  logic          ctrl_we;
`endif

  assign unused = ^{hburst, hmastlock, hprot, haddr[31:4]};

  assign count    = wr_ptr - rd_ptr;
  assign count9   = 9'(count);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign status   = {15'b0, count9, 6'b0, full, empty};
  assign tx_valid = !empty && (gap_cnt == '0);
  assign tx_data  = tx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign pop      = tx_valid && tx_ready;

  assign tohost_valid = (tohost != 32'b0);

  // Address-phase error decode, evaluated on the incoming request
  always_comb begin
    addr_err = (haddr[1:0] != 2'b00) || (hsize > 3'd2);
    unique case (haddr[3:2])
      OFF_ST: if (hwrite) addr_err = 1'b1;
      OFF_TH: if (hsize != 3'd2) addr_err = 1'b1;
`ifdef VSCALE_CONSOLE_IRQ_EN
      OFF_CT: if (hsize != 3'd2) addr_err = 1'b1;
`else
      OFF_CT: addr_err = 1'b1;
`endif
      default: ;
    endcase
  end

  // Data-phase response, register side effects and next state
  always_comb begin
    state_n   = state;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = 32'b0;
    push      = 1'b0;
    tohost_we = 1'b0;
`ifdef VSCALE_CONSOLE_IRQ_EN
    ctrl_we   = 1'b0;
`endif
    unique case (state)
      ST_DATA: begin
        if (dp_write) begin
          unique case (dp_off)
            OFF_TX: begin
              if (full && !pop) hready = 1'b0;
              else push = 1'b1;
            end
            OFF_TH: tohost_we = 1'b1;
`ifdef VSCALE_CONSOLE_IRQ_EN
            OFF_CT: ctrl_we = 1'b1;
`endif
            default: ;
          endcase
        end else begin
          unique case (dp_off)
            OFF_ST: hrdata = status;
            OFF_TH: hrdata = tohost;
`ifdef VSCALE_CONSOLE_IRQ_EN
            OFF_CT: hrdata = {15'b0, watermark, 7'b0, irq_en};
`endif
            default: hrdata = 32'b0;
          endcase
        end
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_n = ST_ERR2;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
    if (hready) begin
      if (htrans[1]) state_n = addr_err ? ST_ERR1 : ST_DATA;
      else state_n = ST_IDLE;
    end
  end

  // Bus state and address-phase capture
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state    <= ST_IDLE;
      dp_off   <= 2'd0;
      dp_write <= 1'b0;
    end else begin
      state <= state_n;
      if (hready && htrans[1]) begin
        dp_off   <= haddr[3:2];
        dp_write <= hwrite;
      end
    end
  end

  // FIFO storage; pointers guard validity so no reset is needed
  always_ff @(posedge hclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= hwdata[7:0];
  end

  // FIFO pointers and output pacing counter
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      gap_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop) gap_cnt <= GW'(GAP);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // tohost mailbox
  always_ff @(posedge hclk) begin
    if (!hresetn) tohost <= 32'b0;
    else if (tohost_we) tohost <= hwdata;
  end

`ifdef VSCALE_CONSOLE_IRQ_EN
  // CTRL register and registered low-watermark interrupt
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      irq_en    <= 1'b0;
      watermark <= 9'd0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_we) begin
        irq_en    <= hwdata[0];
        watermark <= hwdata[16:8];
      end
      irq <= irq_en && (count9 <= watermark);
    end
  end
`endif

endmodule

// File: tb/tb_vscale_hasti_console.sv
// Directed bench for vscale_hasti_console: GAP=0 instance u0, GAP=3 instance u1.
// Both share the bus inputs; u1 is held in reset until the pacing tests.
module tb_vscale_hasti_console;

  logic        clk;
  logic        rst0_n;
  logic        rst1_n;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata;

  logic [31:0] hrdata0, hrdata1;
  logic        hready0, hready1;
  logic        hresp0, hresp1;
  logic        tx_valid0, tx_valid1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_ready0, tx_ready1;
  logic [31:0] tohost0, tohost1;
  logic        tohost_valid0, tohost_valid1;
`ifdef VSCALE_CONSOLE_IRQ_EN
  logic        irq0, irq1;
`endif

  int total = 0;
  int bad   = 0;

  vscale_hasti_console #(.FIFO_DEPTH(16), .GAP(0)) u0 (
    .hclk(clk), .hresetn(rst0_n), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata0), .hready(hready0), .hresp(hresp0),
    .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
    .tohost(tohost0), .tohost_valid(tohost_valid0)
`ifdef VSCALE_CONSOLE_IRQ_EN
    , .irq(irq0)
`endif
  );

  vscale_hasti_console #(.FIFO_DEPTH(16), .GAP(3)) u1 (
    .hclk(clk), .hresetn(rst1_n), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
    .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata1), .hready(hready1), .hresp(hresp1),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .tohost(tohost1), .tohost_valid(tohost_valid1)
`ifdef VSCALE_CONSOLE_IRQ_EN
    , .irq(irq1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // One non-pipelined transfer; returns read data, any hresp, wait count
  task automatic bus(input logic [31:0] a, input logic w,
                     input logic [2:0] s, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err,
                     output int waits);
    @(negedge clk);
    haddr = a; hwrite = w; hsize = s; htrans = 2'd2;
    @(negedge clk);
    htrans = 2'd0; hwdata = wd; #1;
    waits = 0;
    err = 1'b0;
    while (!hready0 && waits < 40) begin
      err = err | hresp0;
      @(negedge clk); #1;
      waits++;
    end
    err = err | hresp0;
    rd = hrdata0;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic e; int w;
    rst0_n = 1'b0; rst1_n = 1'b0;
    tx_ready0 = 1'b0; tx_ready1 = 1'b0;
    haddr = 32'b0; hwrite = 1'b0; hsize = 3'd0; htrans = 2'd0;
    hburst = 3'd0; hmastlock = 1'b0; hprot = 4'd0; hwdata = 32'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({hready0, hresp0, tx_valid0, tohost_valid0} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 1000",
               {hready0, hresp0, tx_valid0, tohost_valid0});
    end
    total++;
    if ({hrdata0, tohost0, tx_data0} !== 72'b0) begin
      bad++;
      $display("FAIL reset_data: got %h %h %h want 0", hrdata0, tohost0, tx_data0);
    end
`ifdef VSCALE_CONSOLE_IRQ_EN
    total++;
    if (irq0 !== 1'b0) begin
      bad++; $display("FAIL reset_irq: got %b want 0", irq0);
    end
`endif
    rst0_n = 1'b1;
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if ({e, r} !== {1'b0, 32'h1} || w != 0) begin
      bad++;
      $display("FAIL reset_status: got err=%b r=%h w=%0d want 0 00000001 0", e, r, w);
    end
  endtask

  task automatic test_tx_basic();
    logic [31:0] r; logic e; int w; int wmax;
    logic [7:0] exp;
    tx_ready0 = 1'b0;
    wmax = 0;
    for (int i = 0; i < 3; i++) begin
      bus(32'h0, 1'b1, 3'd0, 32'hAABBCC41 + i, r, e, w);
      if (w > wmax || e) wmax = w + 100;
    end
    total++;
    if (wmax != 0) begin
      bad++; $display("FAIL tx_push_waits: got %0d want 0", wmax);
    end
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_0300) begin
      bad++; $display("FAIL tx_status3: got %h want 00000300", r);
    end
    @(negedge clk);
    tx_ready0 = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      exp = 8'h41 + 8'(i);
      total++;
      if ({tx_valid0, tx_data0} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL tx_seq%0d: got v=%b d=%h want 1 %h", i, tx_valid0, tx_data0, exp);
      end
      @(negedge clk); #1;
    end
    total++;
    if (tx_valid0 !== 1'b0) begin
      bad++; $display("FAIL tx_drained: got %b want 0", tx_valid0);
    end
    tx_ready0 = 1'b0;
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_0001) begin
      bad++; $display("FAIL tx_status_empty: got %h want 00000001", r);
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] r; logic e; int w; int wmax;
    logic [7:0] exp;
    tx_ready0 = 1'b0;
    wmax = 0;
    for (int i = 0; i < 16; i++) begin
      bus(32'h0, 1'b1, 3'd0, 32'(i), r, e, w);
      if (w > wmax) wmax = w;
    end
    total++;
    if (wmax != 0) begin
      bad++; $display("FAIL fill_waits: got %0d want 0", wmax);
    end
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_1002) begin
      bad++; $display("FAIL full_status: got %h want 00001002", r);
    end
    @(negedge clk);
    haddr = 32'h0; hwrite = 1'b1; hsize = 3'd0; htrans = 2'd2;
    @(negedge clk);
    htrans = 2'd0; hwdata = 32'h10; #1;
    total++;
    if ({hready0, hresp0} !== 2'b00) begin
      bad++; $display("FAIL stall_c1: got %b want 00", {hready0, hresp0});
    end
    @(negedge clk); #1;
    total++;
    if (hready0 !== 1'b0) begin
      bad++; $display("FAIL stall_c2: got %b want 0", hready0);
    end
    tx_ready0 = 1'b1; #1;
    total++;
    if ({hready0, tx_valid0, tx_data0} !== {2'b11, 8'h00}) begin
      bad++;
      $display("FAIL stall_release: got %b %b %h want 1 1 00", hready0, tx_valid0, tx_data0);
    end
    @(negedge clk);
    tx_ready0 = 1'b0; #1;
    total++;
    if ({hready0, tx_valid0, tx_data0} !== {2'b11, 8'h01}) begin
      bad++;
      $display("FAIL stall_after: got %b %b %h want 1 1 01", hready0, tx_valid0, tx_data0);
    end
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_1002) begin
      bad++; $display("FAIL stall_status: got %h want 00001002", r);
    end
    @(negedge clk);
    tx_ready0 = 1'b1; #1;
    for (int i = 1; i <= 16; i++) begin
      exp = 8'(i);
      total++;
      if ({tx_valid0, tx_data0} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL drain%0d: got v=%b d=%h want 1 %h", i, tx_valid0, tx_data0, exp);
      end
      @(negedge clk); #1;
    end
    tx_ready0 = 1'b0;
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_0001) begin
      bad++; $display("FAIL drain_status: got %h want 00000001", r);
    end
  endtask

  task automatic test_tohost();
    logic [31:0] r; logic e; int w;
    bus(32'h8, 1'b1, 3'd2, 32'h1, r, e, w);
    @(negedge clk); #1;
    total++;
    if ({e, tohost_valid0, tohost0} !== {2'b01, 32'h1}) begin
      bad++;
      $display("FAIL tohost_write: got e=%b v=%b %h want 0 1 00000001", e, tohost_valid0, tohost0);
    end
    bus(32'h8, 1'b1, 3'd1, 32'hFFFF, r, e, w);
    @(negedge clk); #1;
    total++;
    if ({e, tohost0} !== {1'b1, 32'h1} || w != 1) begin
      bad++;
      $display("FAIL tohost_half: got e=%b w=%0d %h want 1 1 00000001", e, w, tohost0);
    end
    bus(32'h8, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if ({e, r} !== {1'b0, 32'h1}) begin
      bad++; $display("FAIL tohost_read: got e=%b %h want 0 00000001", e, r);
    end
    bus(32'h8, 1'b1, 3'd2, 32'h0, r, e, w);
    @(negedge clk); #1;
    total++;
    if ({tohost_valid0, tohost0} !== 33'b0) begin
      bad++; $display("FAIL tohost_zero: got v=%b %h want 0 0", tohost_valid0, tohost0);
    end
    bus(32'h8, 1'b1, 3'd2, 32'hCAFE0000, r, e, w);
    @(negedge clk); #1;
    total++;
    if ({tohost_valid0, tohost0} !== {1'b1, 32'hCAFE0000}) begin
      bad++; $display("FAIL tohost_cafe: got v=%b %h want 1 cafe0000", tohost_valid0, tohost0);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int w;
    bus(32'h1, 1'b1, 3'd0, 32'h55, r, e, w);
    total++;
    if (e !== 1'b1 || w != 1) begin
      bad++; $display("FAIL err_misaligned: got e=%b w=%0d want 1 1", e, w);
    end
    bus(32'h4, 1'b1, 3'd2, 32'h0, r, e, w);
    total++;
    if (e !== 1'b1 || w != 1) begin
      bad++; $display("FAIL err_status_wr: got e=%b w=%0d want 1 1", e, w);
    end
    bus(32'h0, 1'b1, 3'd3, 32'h66, r, e, w);
    total++;
    if (e !== 1'b1 || w != 1) begin
      bad++; $display("FAIL err_hsize3: got e=%b w=%0d want 1 1", e, w);
    end
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if ({e, r} !== {1'b0, 32'h1}) begin
      bad++; $display("FAIL err_no_push: got e=%b %h want 0 00000001", e, r);
    end
  endtask

`ifdef VSCALE_CONSOLE_IRQ_EN
  task automatic test_ctrl();
    logic [31:0] r; logic e; int w;
    tx_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) bus(32'h0, 1'b1, 3'd0, 32'h61 + i, r, e, w);
    bus(32'hC, 1'b1, 3'd2, 32'h0000_0201, r, e, w);
    total++;
    if (e !== 1'b0 || w != 0) begin
      bad++; $display("FAIL ctrl_write: got e=%b w=%0d want 0 0", e, w);
    end
    bus(32'hC, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_0201) begin
      bad++; $display("FAIL ctrl_read: got %h want 00000201", r);
    end
    bus(32'hC, 1'b1, 3'd0, 32'h0, r, e, w);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL ctrl_byte: got e=%b want 1", e);
    end
    total++;
    if (irq0 !== 1'b0) begin
      bad++; $display("FAIL irq_count5: got %b want 0", irq0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); tx_ready0 = 1'b1;
      @(negedge clk); tx_ready0 = 1'b0;
    end
    #1;
    total++;
    if (irq0 !== 1'b0) begin
      bad++; $display("FAIL irq_same_cycle: got %b want 0", irq0);
    end
    @(negedge clk); #1;
    total++;
    if (irq0 !== 1'b1) begin
      bad++; $display("FAIL irq_rise: got %b want 1", irq0);
    end
    tx_ready0 = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready0 = 1'b0;
  endtask
`else
  task automatic test_ctrl();
    logic [31:0] r; logic e; int w;
    bus(32'hC, 1'b1, 3'd2, 32'h0000_0201, r, e, w);
    total++;
    if (e !== 1'b1 || w != 1) begin
      bad++; $display("FAIL ctrl_wr_err: got e=%b w=%0d want 1 1", e, w);
    end
    bus(32'hC, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if ({e, r} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL ctrl_rd_err: got e=%b %h want 1 0", e, r);
    end
  endtask
`endif

  task automatic test_stall_reset();
    logic [31:0] r; logic e; int w;
    tx_ready0 = 1'b0;
    for (int i = 0; i < 16; i++) bus(32'h0, 1'b1, 3'd0, 32'h20 + i, r, e, w);
    @(negedge clk);
    haddr = 32'h0; hwrite = 1'b1; hsize = 3'd0; htrans = 2'd2;
    @(negedge clk);
    htrans = 2'd0; hwdata = 32'h99; #1;
    total++;
    if (hready0 !== 1'b0) begin
      bad++; $display("FAIL rst_stall_pre: got %b want 0", hready0);
    end
    rst0_n = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({hready0, hresp0, tx_valid0, tohost_valid0} !== 4'b1000 ||
        {hrdata0, tohost0, tx_data0} !== 72'b0) begin
      bad++;
      $display("FAIL rst_stall_out: got %b %b %b %b %h %h want 1 0 0 0 0 0",
               hready0, hresp0, tx_valid0, tohost_valid0, hrdata0, tohost0);
    end
`ifdef VSCALE_CONSOLE_IRQ_EN
    total++;
    if (irq0 !== 1'b0) begin
      bad++; $display("FAIL rst_irq: got %b want 0", irq0);
    end
`endif
    rst0_n = 1'b1;
    bus(32'h4, 1'b0, 3'd2, 32'b0, r, e, w);
    total++;
    if (r !== 32'h0000_0001) begin
      bad++; $display("FAIL rst_status: got %h want 00000001", r);
    end
  endtask

  task automatic test_gap();
    logic [31:0] r; logic e; int w;
    logic       ev;
    logic [7:0] ed;
    int         seen;
    @(negedge clk);
    rst1_n = 1'b1;
    tx_ready0 = 1'b1;
    tx_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) bus(32'h0, 1'b1, 3'd0, 32'h51 + i, r, e, w);
    @(negedge clk);
    tx_ready1 = 1'b1; #1;
    for (int c = 0; c < 18; c++) begin
      ev = (c % 4 == 0) && (c < 16);
      ed = ev ? 8'h51 + 8'(c / 4) : 8'h00;
      total++;
      if ({tx_valid1, tx_data1} !== {ev, ed}) begin
        bad++;
        $display("FAIL gap_c%0d: got v=%b d=%h want %b %h", c, tx_valid1, tx_data1, ev, ed);
      end
      @(negedge clk); #1;
    end
    tx_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) bus(32'h0, 1'b1, 3'd0, 32'h71 + i, r, e, w);
    @(negedge clk);
    tx_ready1 = 1'b1; #1;
    total++;
    if ({tx_valid1, tx_data1} !== {1'b1, 8'h71}) begin
      bad++; $display("FAIL gap_rst_first: got %b %h want 1 71", tx_valid1, tx_data1);
    end
    @(negedge clk); #1;
    rst1_n = 1'b0;
    @(negedge clk); #1;
    total++;
    if ({tx_valid1, tx_data1, hready1} !== {1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL gap_rst_edge: got %b %h %b want 0 00 1", tx_valid1, tx_data1, hready1);
    end
    rst1_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (tx_valid1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL gap_rst_empty: got %0d valid cycles want 0", seen);
    end
    tx_ready1 = 1'b0;
    tx_ready0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_full_stall();
    test_tohost();
    test_errors();
    test_ctrl();
    test_stall_reset();
    test_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
